// File: rtl/bcd_2digit_updn_counter_pkg.sv
// Shared definitions for the two-digit BCD up/down counter: digit width,
// largest legal digit value, direction encodings and a BCD validity helper.
package bcd_2digit_updn_counter_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] DIGIT_ZERO = 4'd0;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // True when the nibble is a legal BCD digit (0-9).
    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_2digit_updn_counter_digit.sv
// One BCD decade. Holds a digit 0-9, steps up or down, wraps 9->0 / 0->9
// and flags the wrap on carry so the next decade can be stepped from it.
// A load always wins over a step in the same cycle.
module bcd_digit
    import bcd_2digit_updn_counter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               up_dn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    // Next digit value and carry/borrow out of this decade.
    always_comb begin
        digit_d = digit_q;
        carry   = 1'b0;
        if (load) begin
            digit_d = load_digit;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (digit_q >= DIGIT_MAX) begin
                    digit_d = DIGIT_ZERO;
                    carry   = 1'b1;
                end else begin
                    digit_d = digit_q + 4'd1;
                end
            end else begin
                if (digit_q == DIGIT_ZERO) begin
                    digit_d = DIGIT_MAX;
                    carry   = 1'b1;
                end else begin
                    digit_d = digit_q - 4'd1;
                end
            end
        end
    end

    // Digit register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= DIGIT_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_2digit_updn_counter.sv
// Two-digit BCD up/down counter with a clock prescaler, validated
// synchronous load, a terminal-count pulse and an invalid-load pulse.
// All outputs come straight from flops.
module bcd_2digit_updn_counter
    import bcd_2digit_updn_counter_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up_dn,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tc,
    output logic       load_err
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tc_q;
    logic               tc_d;
    logic               load_err_q;
    logic               load_err_d;

    logic tick;
    logic step;
    logic load_ok;
    logic ones_carry;
    logic tens_carry;

    // Step generation, load validation and next prescaler / pulse values.
    // A load (valid or not) swallows a coincident step; an invalid load
    // freezes the prescaler so the pending step is not lost or advanced.
    always_comb begin
        tick       = en && (presc_q == PRESC_MAX);
        load_ok    = load && is_bcd(load_val[7:4]) && is_bcd(load_val[3:0]);
        step       = tick && !load;
        presc_d    = presc_q;
        tc_d       = tens_carry;
        load_err_d = load && !load_ok;
        if (load) begin
            if (load_ok) begin
                presc_d = '0;
            end
        end else if (en) begin
            if (tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end
    end

    // Prescaler and output pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q    <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    bcd_digit u_ones (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step),
        .up_dn      (up_dn),
        .load       (load_ok),
        .load_digit (load_val[3:0]),
        .digit      (ones),
        .carry      (ones_carry)
    );

    // The tens decade only moves when the ones decade wraps, so its carry
    // marks a full 99->00 or 00->99 wrap.
    bcd_digit u_tens (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (ones_carry),
        .up_dn      (up_dn),
        .load       (load_ok),
        .load_digit (load_val[7:4]),
        .digit      (tens),
        .carry      (tens_carry)
    );

    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_2digit_updn_counter.sv
// Self-checking bench for bcd_2digit_updn_counter with TICK_DIV=4.
// A decimal reference model predicts each cycle's outputs; predictions are
// queued as stimulus is driven and compared after the clock edge.
module tb_bcd_2digit_updn_counter;

    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       tc;
    logic       load_err;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       tc;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    int m_cnt   = 0;
    int m_presc = 0;
    logic m_tc  = 1'b0;
    logic m_err = 1'b0;

    bcd_2digit_updn_counter #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .ones     (ones),
        .tens     (tens),
        .tc       (tc),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal count 0..99, advanced once per clock.
    task automatic model_step(input logic r, input logic e, input logic u,
                              input logic l, input logic [7:0] lv);
        int  t, o;
        logic tick;
        t = int'(lv[7:4]);
        o = int'(lv[3:0]);
        if (!r) begin
            m_cnt = 0; m_presc = 0; m_tc = 1'b0; m_err = 1'b0;
        end else begin
            tick  = e && (m_presc == TD - 1);
            m_tc  = 1'b0;
            m_err = 1'b0;
            if (l) begin
                if (t <= 9 && o <= 9) begin
                    m_cnt   = t * 10 + o;
                    m_presc = 0;
                end else begin
                    m_err = 1'b1;
                end
            end else if (e) begin
                if (tick) begin
                    m_presc = 0;
                    if (u) begin
                        if (m_cnt == 99) begin m_cnt = 0; m_tc = 1'b1; end
                        else m_cnt = m_cnt + 1;
                    end else begin
                        if (m_cnt == 0) begin m_cnt = 99; m_tc = 1'b1; end
                        else m_cnt = m_cnt - 1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
        end
    endtask

    // Drive one cycle, queue the prediction, then compare after the edge.
    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic l, input logic [7:0] lv);
        exp_t x;
        rst_n = r; en = e; up_dn = u; load = l; load_val = lv;
        model_step(r, e, u, l, lv);
        x.tens = 4'(m_cnt / 10);
        x.ones = 4'(m_cnt % 10);
        x.tc   = m_tc;
        x.err  = m_err;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=0 exp=1");
        end else begin
            x = sb_q.pop_front();
            checks++;
            assert ({tens, ones, tc, load_err} === {x.tens, x.ones, x.tc, x.err})
            else begin
                failures++;
                $error("FAIL sb t=%0t got tens=%0d ones=%0d tc=%0b err=%0b exp tens=%0d ones=%0d tc=%0b err=%0b",
                       $time, tens, ones, tc, load_err, x.tens, x.ones, x.tc, x.err);
            end
        end
    endtask

    // Directed check against a hand-derived constant.
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n, input logic e, input logic u);
        for (int i = 0; i < n; i++) cyc(1'b1, e, u, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;

        // Reset overrides a coincident load and enable.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("reset_cnt", int'({tens, ones}), 0);
        chk("reset_tc_err", int'({tc, load_err}), 0);

        // Count up from reset: steps at enabled cycles 4, 8, 12.
        run(3, 1'b1, 1'b1);
        chk("up_before_first", int'(ones), 0);
        run(1, 1'b1, 1'b1);
        chk("up_first_step", int'(ones), 1);
        run(8, 1'b1, 1'b1);
        chk("up_12cyc_ones", int'(ones), 3);
        chk("up_12cyc_tens", int'(tens), 0);

        // Enable low holds the prescaler and the count.
        run(5, 1'b0, 1'b1);
        chk("hold_en0", int'(ones), 3);

        // Load 98, count up through 99 to 00 with a single tc pulse.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h98);
        run(4, 1'b1, 1'b1);
        chk("up_to_99", int'({tens, ones}), 8'h99);
        run(4, 1'b1, 1'b1);
        chk("wrap_00", int'({tens, ones}), 8'h00);
        chk("wrap_tc", int'(tc), 1);
        run(1, 1'b1, 1'b1);
        chk("tc_one_cycle", int'(tc), 0);

        // Load 00 with en low, count down: 99 with tc, then 98 without.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        run(4, 1'b1, 1'b0);
        chk("dn_wrap_99", int'({tens, ones}), 8'h99);
        chk("dn_wrap_tc", int'(tc), 1);
        run(4, 1'b1, 1'b0);
        chk("dn_98", int'({tens, ones}), 8'h98);
        chk("dn_98_tc", int'(tc), 0);

        // Invalid loads leave the count alone and pulse load_err.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h5A);
        chk("bad_5A_err", int'(load_err), 1);
        chk("bad_5A_cnt", int'({tens, ones}), 8'h98);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
        chk("bad_A5_err", int'(load_err), 1);
        run(1, 1'b1, 1'b0);
        chk("err_one_cycle", int'(load_err), 0);

        // Load coinciding with a step: step discarded, prescaler restarts.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h10);
        run(3, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h42);
        chk("coinc_cnt", int'({tens, ones}), 8'h42);
        chk("coinc_tc", int'(tc), 0);
        run(3, 1'b1, 1'b1);
        chk("coinc_no_early", int'({tens, ones}), 8'h42);
        run(1, 1'b1, 1'b1);
        chk("coinc_restart", int'({tens, ones}), 8'h43);

        // Direction change between steps takes effect on the next step.
        run(4, 1'b1, 1'b0);
        chk("dir_change", int'({tens, ones}), 8'h42);

        // Reset mid-count with load asserted.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h37);
        run(2, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h37);
        chk("midrst_cnt", int'({tens, ones}), 0);
        chk("midrst_tc_err", int'({tc, load_err}), 0);
        run(3, 1'b1, 1'b1);
        chk("midrst_wait", int'(ones), 0);
        run(1, 1'b1, 1'b1);
        chk("midrst_step", int'(ones), 1);

        // Randomised traffic checked by the model only.
        for (int i = 0; i < 200; i++) begin
            logic [7:0] lv;
            lv = 8'($urandom);
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                1'($urandom), ($urandom_range(0, 9) == 0), lv);
            checks++;
            assert (tens <= 4'd9 && ones <= 4'd9)
            else begin
                failures++;
                $error("FAIL bcd_range got tens=%0d ones=%0d exp<=9", tens, ones);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
